// File: rtl/load_store_unit.sv
// load_store_unit: CPU load/store FSM to big-endian memory with sub-word read-modify-write; ports: req* CPU request, resp* completion, mem* memory side
module load_store_unit #(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [1:0]  reqSize,
  input  logic        reqSigned,
  input  logic [31:0] reqAddress,
  input  logic [31:0] reqData,
  output logic        respValid,
  output logic        respError,
  output logic [31:0] respData,
  output logic [31:0] memAddress,
  output logic        memReadEnable,
  output logic        memWriteEnable,
  output logic [31:0] memDataOut,
  input  logic [31:0] memDataIn
);
  typedef enum logic [2:0] {IDLE, LOAD, RMW_READ, STORE, RESP} state_t;
  state_t state, state_n;
  logic [1:0] size_q;
  logic signed_q, err_q, bad;
  logic [31:0] addr_q, wdata_q, rdata_q, ld_ext, merged;
  assign bad = reqSize == 2'b11 || (ALIGN_CHECK && ((reqSize == 2'b01 && reqAddress[0]) || (reqSize == 2'b10 && reqAddress[1:0] != 2'b00)));
  assign ld_ext = size_q == 2'b00 ? {{24{signed_q & memDataIn[31]}}, memDataIn[31:24]} :
                  size_q == 2'b01 ? {{16{signed_q & memDataIn[31]}}, memDataIn[31:16]} : memDataIn;
  assign merged = size_q == 2'b00 ? {wdata_q[7:0], memDataIn[23:0]} : {wdata_q[15:0], memDataIn[15:0]};
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = !reqValid ? IDLE : bad ? RESP : !reqWrite ? LOAD : reqSize == 2'b10 ? STORE : RMW_READ;
      LOAD:     state_n = RESP;
      RMW_READ: state_n = STORE;
      STORE:    state_n = RESP;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && reqValid) begin
        size_q   <= reqSize;
        signed_q <= reqSigned;
        err_q    <= bad;
        addr_q   <= reqAddress;
        wdata_q  <= reqData;
        rdata_q  <= '0;
      end
      if (state == LOAD) rdata_q <= ld_ext;
      if (state == RMW_READ) wdata_q <= merged;
    end
  end
  assign reqReady       = state == IDLE;
  assign respValid      = state == RESP;
  assign respError      = state == RESP && err_q;
  assign respData       = state == RESP ? rdata_q : '0;
  assign memReadEnable  = state == LOAD || state == RMW_READ;
  assign memWriteEnable = state == STORE;
  assign memAddress     = (memReadEnable || memWriteEnable) ? addr_q : '0;
  assign memDataOut     = memWriteEnable ? wdata_q : '0;
endmodule
